mult_share_arbiter: RTL

- Shares one iterative shift-add multiplier between two requesters.
- Each requester presents a pair of W-bit operands and a level request.
- A round-robin arbiter grants the multiplier, the block computes the 2W-bit product over W cycles, then pulses a per-channel done.
- Sits between the debounced user-input/counter logic and the top-level output mux. It replaces the wide combinational product with a time-shared sequential unit.

---
 rtl/mult_share_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier between two requesters.
// Each job takes W CALC cycles, then a one-cycle DONE that pulses done[owner].
module mult_share_arbiter #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b0,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    output logic             busy,
    output logic             owner,
    output logic [1:0]       done,
    output logic [2*W-1:0]   result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             owner_q, owner_d;
    logic [1:0]       done_q, done_d;
    logic [2*W-1:0]   result_q, result_d;
    logic             rr_last_q, rr_last_d;
    logic [1:0]       armed_q, armed_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]    step_q, step_d;

    logic [1:0]       ereq;
    logic             gnt;
    logic [2*W-1:0]   sum;

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        owner_d   = owner_q;
        done_d    = '0;
        result_d  = result_q;
        rr_last_d = rr_last_q;
        armed_d   = armed_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        step_d    = step_q;
        gnt       = 1'b0;
        sum       = acc_q + (mplier_q[0] ? mcand_q : '0);
        ereq      = req & armed_q;

        // A low request re-arms; completion disarms below, and wins if both apply
        for (int unsigned i = 0; i < 2; i++) begin
            if (!req[i]) armed_d[i] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (ereq != 2'b00) begin
                    gnt      = (ereq == 2'b11) ? ~rr_last_q : ereq[1];
                    owner_d  = gnt;
                    busy_d   = 1'b1;
                    mcand_d  = {{W{1'b0}}, (gnt ? a1 : a0)};
                    mplier_d = gnt ? b1 : b0;
                    acc_d    = '0;
                    step_d   = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                step_d   = step_q + CW'(1);
                if (step_q == CW'(W - 1)) begin
                    result_d         = sum;
                    done_d[owner_q]  = 1'b1;
                    rr_last_d        = owner_q;
                    armed_d[owner_q] = 1'b0;
                    state_d          = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            owner_q   <= 1'b0;
            done_q    <= '0;
            result_q  <= '0;
            rr_last_q <= 1'b1;
            armed_q   <= 2'b11;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            owner_q   <= owner_d;
            done_q    <= done_d;
            result_q  <= result_d;
            rr_last_q <= rr_last_d;
            armed_q   <= armed_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            step_q    <= step_d;
        end
    end

    assign busy   = busy_q;
    assign owner  = owner_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
